// File: rtl/memory_mp_timed_if.sv
// Request/response bundle for memory_mp_timed; per-port fields are flattened, port p in slice p.
// The wmask field exists only when MEM_BYTE_MASK_EN is defined.
interface memory_mp_timed_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_SIZE  = 12,
  parameter int LINE_WIDTH = 128
);
  logic [NUM_PORTS-1:0]            req;
  logic [NUM_PORTS-1:0]            we;
  logic [NUM_PORTS*ADDR_SIZE-1:0]  addr;
  logic [NUM_PORTS*LINE_WIDTH-1:0] wdata;
`ifdef MEM_BYTE_MASK_EN
  logic [NUM_PORTS*LINE_WIDTH/8-1:0] wmask;
`endif
  logic [NUM_PORTS*LINE_WIDTH-1:0] rdata;
  logic [NUM_PORTS-1:0]            ready;
  logic [NUM_PORTS-1:0]            busy;
  logic [NUM_PORTS-1:0]            addr_err;

  modport master (
    output req, we, addr, wdata,
`ifdef MEM_BYTE_MASK_EN
    output wmask,
`endif
    input  rdata, ready, busy, addr_err
  );

  modport slave (
    input  req, we, addr, wdata,
`ifdef MEM_BYTE_MASK_EN
    input  wmask,
`endif
    output rdata, ready, busy, addr_err
  );
endinterface

// File: rtl/memory_mp_timed.sv
// Multi-port main memory with a fixed LATENCY access pipeline per port and a built-in
// reset image (byte value 0x11*(line+1)). Optional byte write mask: MEM_BYTE_MASK_EN.
module memory_mp_timed #(
  parameter int LINE_WIDTH     = 128,
  parameter int ADDR_SIZE      = 12,
  parameter int LINE_ADDR_SIZE = 8,
  parameter int LINES          = 16,
  parameter int NUM_PORTS      = 2,
  parameter int LATENCY        = 5
) (
  input  logic              clk,
  input  logic              reset,
  memory_mp_timed_if.slave  mem_if
);
  localparam int IDX_W  = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int MASK_W = LINE_WIDTH / 8;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_e;

  state_e                    state_q [NUM_PORTS];
  state_e                    state_d [NUM_PORTS];
  logic [CNT_W-1:0]          cnt_q   [NUM_PORTS];
  logic [CNT_W-1:0]          cnt_d   [NUM_PORTS];
  logic [LINE_ADDR_SIZE-1:0] line_q  [NUM_PORTS];
  logic [LINE_ADDR_SIZE-1:0] line_d  [NUM_PORTS];
  logic [LINE_WIDTH-1:0]     wdata_q [NUM_PORTS];
  logic [LINE_WIDTH-1:0]     wdata_d [NUM_PORTS];
  logic [LINE_WIDTH-1:0]     rdata_q [NUM_PORTS];
  logic [LINE_WIDTH-1:0]     rdata_d [NUM_PORTS];
`ifdef MEM_BYTE_MASK_EN
  logic [MASK_W-1:0]         wmask_q [NUM_PORTS];
  logic [MASK_W-1:0]         wmask_d [NUM_PORTS];
`endif
  logic [NUM_PORTS-1:0]      we_q, we_d, ready_q, ready_d, busy_q, busy_d, err_q, err_d;
  logic [NUM_PORTS-1:0]      commit_s, in_range_s;
  logic [LINE_WIDTH-1:0]     merged_s [NUM_PORTS];
  logic [LINE_WIDTH-1:0]     mem_q [LINES];
  logic [LINE_WIDTH-1:0]     mem_d [LINES];

  function automatic logic [LINE_WIDTH-1:0] image_line(input int idx);
    logic [7:0] b;
    b = 8'((idx + 1) * 17);
    return {MASK_W{b}};
  endfunction

  function automatic logic [LINE_WIDTH-1:0] expand_mask(input logic [MASK_W-1:0] m);
    logic [LINE_WIDTH-1:0] r;
    r = {LINE_WIDTH{1'b0}};
    for (int i = 0; i < MASK_W; i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

  // Commit detection, byte merge and the post-commit memory view (ascending port order => highest wins).
  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      logic [LINE_WIDTH-1:0] bm;
`ifdef MEM_BYTE_MASK_EN
      bm = expand_mask(wmask_q[p]);
`else
      bm = {LINE_WIDTH{1'b1}};
`endif
      commit_s[p]   = (state_q[p] == ST_BUSY) && (cnt_q[p] == CNT_W'(0));
      in_range_s[p] = (line_q[p] < LINE_ADDR_SIZE'(LINES));
      merged_s[p]   = (mem_q[line_q[p][IDX_W-1:0]] & ~bm) | (wdata_q[p] & bm);
      mem_d[line_q[p][IDX_W-1:0]] = (commit_s[p] && we_q[p] && in_range_s[p]) ?
                                    merged_s[p] : mem_d[line_q[p][IDX_W-1:0]];
    end
  end

  // Per-port FSM next state and registered outputs.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      logic [LINE_ADDR_SIZE-1:0] req_line;
      req_line   = mem_if.addr[p*ADDR_SIZE + ADDR_SIZE-1 -: LINE_ADDR_SIZE];
      state_d[p] = state_q[p];
      cnt_d[p]   = cnt_q[p];
      line_d[p]  = line_q[p];
      wdata_d[p] = wdata_q[p];
      we_d[p]    = we_q[p];
      busy_d[p]  = busy_q[p];
      err_d[p]   = err_q[p];
      ready_d[p] = 1'b0;
      rdata_d[p] = {LINE_WIDTH{1'b0}};
`ifdef MEM_BYTE_MASK_EN
      wmask_d[p] = wmask_q[p];
`endif
      case (state_q[p])
        ST_IDLE: begin
          if (mem_if.req[p]) begin
            state_d[p] = ST_BUSY;
            cnt_d[p]   = CNT_W'(LATENCY - 1);
            line_d[p]  = req_line;
            wdata_d[p] = mem_if.wdata[p*LINE_WIDTH +: LINE_WIDTH];
            we_d[p]    = mem_if.we[p];
            busy_d[p]  = 1'b1;
            err_d[p]   = err_q[p] | (req_line >= LINE_ADDR_SIZE'(LINES));
`ifdef MEM_BYTE_MASK_EN
            wmask_d[p] = mem_if.wmask[p*MASK_W +: MASK_W];
`endif
          end else begin
            state_d[p] = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (commit_s[p]) begin
            state_d[p] = ST_DONE;
            busy_d[p]  = 1'b0;
            ready_d[p] = 1'b1;
            if (!in_range_s[p]) begin
              rdata_d[p] = {LINE_WIDTH{1'b0}};
            end else if (we_q[p]) begin
              rdata_d[p] = merged_s[p];
            end else begin
              rdata_d[p] = mem_d[line_q[p][IDX_W-1:0]];
            end
          end else begin
            cnt_d[p] = cnt_q[p] - CNT_W'(1);
          end
        end
        ST_DONE: state_d[p] = ST_IDLE;
        default: state_d[p] = ST_IDLE;
      endcase
    end
  end

  // State, pipeline and memory registers; reset reloads the image and drops in-flight accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= ST_IDLE;
        cnt_q[p]   <= CNT_W'(0);
        line_q[p]  <= {LINE_ADDR_SIZE{1'b0}};
        wdata_q[p] <= {LINE_WIDTH{1'b0}};
        rdata_q[p] <= {LINE_WIDTH{1'b0}};
`ifdef MEM_BYTE_MASK_EN
        wmask_q[p] <= {MASK_W{1'b0}};
`endif
      end
      we_q    <= {NUM_PORTS{1'b0}};
      ready_q <= {NUM_PORTS{1'b0}};
      busy_q  <= {NUM_PORTS{1'b0}};
      err_q   <= {NUM_PORTS{1'b0}};
      for (int l = 0; l < LINES; l++) mem_q[l] <= image_line(l);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_BYTE_MASK_EN
      wmask_q <= wmask_d;
`endif
      we_q    <= we_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  assign mem_if.ready    = ready_q;
  assign mem_if.busy     = busy_q;
  assign mem_if.addr_err = err_q;
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rdata
    assign mem_if.rdata[g*LINE_WIDTH +: LINE_WIDTH] = rdata_q[g];
  end
endmodule
